controller_dpram_scrub: RTL and testbench

//  Parametrised true dual-port on-chip RAM for the controller subsystem, two Avalon-MM slaves (s1, s2).

---
 rtl/controller_dpram_scrub_if.sv | 28 ++
 rtl/controller_dpram_scrub.sv | 126 ++++++++++++
 tb/tb_controller_dpram_scrub.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_dpram_scrub_if.sv
// rtl/controller_dpram_scrub_if.sv - Avalon-MM style slave port bundle for one RAM port
interface controller_dpram_scrub_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] address;
    logic [BE_WIDTH-1:0]   byteenable;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic                  clken;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata, clken,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata, clken,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/controller_dpram_scrub.sv
// rtl/controller_dpram_scrub.sv - true dual-port RAM with read pipeline, collision flag and clear engine
module controller_dpram_scrub #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 11,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_reset_req,
    input  logic                     i_clear_req,
    output logic                     o_busy,
    output logic                     o_collision,
    controller_dpram_scrub_if.slave  s1,
    controller_dpram_scrub_if.slave  s2
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH    = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_coll;

    logic [DATA_WIDTH-1:0] r_d1 [2];
    logic [DATA_WIDTH-1:0] r_d2 [2];
    logic                  r_v1 [2];
    logic                  r_v2 [2];

    logic                  w_clearing;
    logic                  w_clr_we;
    logic                  w_acc1, w_acc2;
    logic                  w_wr1, w_wr2;
    logic                  w_rd [2];
    logic [ADDR_WIDTH-1:0] w_addr [2];

    assign w_clearing = (r_state == ST_CLEAR);
    assign w_clr_we   = w_clearing & ~i_reset_req & ~i_reset;

    assign s1.waitrequest = w_clearing | ~s1.clken | i_reset_req;
    assign s2.waitrequest = w_clearing | ~s2.clken | i_reset_req;

    // Write wins over read when a master raises both in the same cycle.
    assign w_acc1 = s1.chipselect & (s1.read | s1.write) & ~s1.waitrequest & ~i_reset;
    assign w_acc2 = s2.chipselect & (s2.read | s2.write) & ~s2.waitrequest & ~i_reset;
    assign w_wr1  = w_acc1 & s1.write;
    assign w_wr2  = w_acc2 & s2.write;
    assign w_rd[0]   = w_acc1 & ~s1.write;
    assign w_rd[1]   = w_acc2 & ~s2.write;
    assign w_addr[0] = s1.address;
    assign w_addr[1] = s2.address;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (!i_reset_req && (&r_clr_cnt)) w_state_next = ST_RUN;
            ST_RUN:   if (i_clear_req && !i_reset_req)  w_state_next = ST_CLEAR;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // Counter sits at zero in RUN so every clear starts from the bottom.
    always_ff @(posedge i_clk) begin
        if (i_reset || r_state == ST_RUN) begin
            r_clr_cnt <= '0;
        end else if (!i_reset_req) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // s1 is written last so it owns any overlapping byte lanes.
    always_ff @(posedge i_clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= CLEAR_VALUE;
        end
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (w_wr2 && s2.byteenable[b]) r_mem[s2.address][b*8 +: 8] <= s2.writedata[b*8 +: 8];
            if (w_wr1 && s1.byteenable[b]) r_mem[s1.address][b*8 +: 8] <= s1.writedata[b*8 +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < 2; p++) begin
                r_d1[p] <= '0;
                r_d2[p] <= '0;
                r_v1[p] <= 1'b0;
                r_v2[p] <= 1'b0;
            end
        end else if (!i_reset_req) begin
            for (int p = 0; p < 2; p++) begin
                r_v1[p] <= w_rd[p];
                if (w_rd[p]) r_d1[p] <= r_mem[w_addr[p]];
                r_v2[p] <= r_v1[p];
                if (r_v1[p]) r_d2[p] <= r_d1[p];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_wr1 & w_wr2 & (s1.address == s2.address);
        end
    end

    assign s1.readdata      = (OUT_REG != 0) ? r_d2[0] : r_d1[0];
    assign s1.readdatavalid = (OUT_REG != 0) ? r_v2[0] : r_v1[0];
    assign s2.readdata      = (OUT_REG != 0) ? r_d2[1] : r_d1[1];
    assign s2.readdatavalid = (OUT_REG != 0) ? r_v2[1] : r_v1[1];
    assign o_busy           = w_clearing;
    assign o_collision      = r_coll;
endmodule

// File: tb/tb_controller_dpram_scrub.sv
// tb/tb_controller_dpram_scrub.sv - bench for controller_dpram_scrub, both read latencies side by side
module tb_controller_dpram_scrub;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 2048;
    localparam int HMAX  = 16384;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_req = 1'b0;
    logic clear_req = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] t_addr [2];
    logic [3:0]    t_be   [2];
    logic          t_cs   [2];
    logic          t_rd   [2];
    logic          t_wr   [2];
    logic          t_ck   [2];
    logic [31:0]   t_wd   [2];

    logic [31:0] o_rd [4];
    logic        o_rv [4];
    logic        o_wt [4];
    logic        busy_w [2];
    logic        coll_w [2];

    int n_cmp = 0;
    int n_bad = 0;

    // index k = instance*2 + port; instance 0 has OUT_REG=0, instance 1 has OUT_REG=1
    controller_dpram_scrub_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa [4] ();

    for (genvar k = 0; k < 4; k++) begin : g_if
        assign ifa[k].address    = t_addr[k % 2];
        assign ifa[k].byteenable = t_be[k % 2];
        assign ifa[k].chipselect = t_cs[k % 2];
        assign ifa[k].read       = t_rd[k % 2];
        assign ifa[k].write      = t_wr[k % 2];
        assign ifa[k].writedata  = t_wd[k % 2];
        assign ifa[k].clken      = t_ck[k % 2];
        assign o_rd[k] = ifa[k].readdata;
        assign o_rv[k] = ifa[k].readdatavalid;
        assign o_wt[k] = ifa[k].waitrequest;
    end

    controller_dpram_scrub #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) dut0 (
        .i_clk(clk), .i_reset(reset), .i_reset_req(reset_req), .i_clear_req(clear_req),
        .o_busy(busy_w[0]), .o_collision(coll_w[0]), .s1(ifa[0]), .s2(ifa[1]));

    controller_dpram_scrub #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_reset_req(reset_req), .i_clear_req(clear_req),
        .o_busy(busy_w[1]), .o_collision(coll_w[1]), .s1(ifa[2]), .s2(ifa[3]));

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Model: memory array, remaining clear cycles, and a per-tick history of accepted reads.
    // Ticks advance on every edge that is not frozen by reset_req; a read taken at tick t
    // is visible after tick t+L-1 for latency L.
    bit [31:0] m_mem [DEPTH];
    int        clear_left = 0;
    int        tk = 1;
    bit        h_acc [2][HMAX];
    bit [31:0] h_dat [2][HMAX];
    logic [31:0] e_rd [4];
    logic        e_rv [4];
    logic        e_coll = 1'b0;

    always @(posedge clk) begin
        bit        acc [2];
        bit        wr  [2];
        bit        rda [2];
        bit [31:0] rdat [2];
        bit        busy_pre;
        busy_pre = (clear_left > 0);
        for (int p = 0; p < 2; p++) begin
            acc[p]  = !reset && !reset_req && !busy_pre && t_ck[p] && t_cs[p] && (t_rd[p] || t_wr[p]);
            wr[p]   = acc[p] && t_wr[p];
            rda[p]  = acc[p] && !t_wr[p];
            rdat[p] = m_mem[t_addr[p]];
        end
        e_coll = wr[0] && wr[1] && (t_addr[0] == t_addr[1]);
        if (reset) begin
            if (tk < HMAX - 1) tk++;
            for (int p = 0; p < 2; p++) begin
                h_acc[p][tk]     = 1'b0;
                h_acc[p][tk - 1] = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                e_rd[k] = '0;
                e_rv[k] = 1'b0;
            end
            clear_left = DEPTH;
            for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        end else if (!reset_req) begin
            for (int p = 1; p >= 0; p--) begin
                if (wr[p]) begin
                    for (int b = 0; b < 4; b++)
                        if (t_be[p][b]) m_mem[t_addr[p]][b*8 +: 8] = t_wd[p][b*8 +: 8];
                end
            end
            if (tk < HMAX - 1) tk++;
            for (int p = 0; p < 2; p++) begin
                h_acc[p][tk] = rda[p];
                h_dat[p][tk] = rdat[p];
                for (int inst = 0; inst < 2; inst++) begin
                    e_rv[inst*2 + p] = h_acc[p][tk - inst];
                    if (e_rv[inst*2 + p]) e_rd[inst*2 + p] = h_dat[p][tk - inst];
                end
            end
            if (busy_pre) begin
                clear_left--;
            end else if (clear_req) begin
                clear_left = DEPTH;
                for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                chk("readdatavalid", k, 32'(o_rv[k]), 32'(e_rv[k]));
                chk("readdata", k, o_rd[k], e_rd[k]);
                chk("waitrequest", k, 32'(o_wt[k]), 32'((clear_left > 0) || !t_ck[k % 2] || reset_req));
            end
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, 32'(busy_w[i]), 32'(clear_left > 0));
                chk("collision", i, 32'(coll_w[i]), 32'(e_coll));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        t_cs[p] = 1'b1; t_wr[p] = 1'b1; t_addr[p] = a; t_wd[p] = d; t_be[p] = be;
        step();
        t_cs[p] = 1'b0; t_wr[p] = 1'b0;
    endtask

    task automatic rd_chk(input int p, input logic [AW-1:0] a, input logic [31:0] exp, input string nm);
        t_cs[p] = 1'b1; t_rd[p] = 1'b1; t_addr[p] = a;
        step();
        t_cs[p] = 1'b0; t_rd[p] = 1'b0;
        chk({nm, "_valid_lat1"}, p, 32'(o_rv[p]), 32'd1);
        chk({nm, "_data_lat1"}, p, o_rd[p], exp);
        chk({nm, "_early_lat2"}, p, 32'(o_rv[2 + p]), 32'd0);
        step();
        chk({nm, "_valid_lat2"}, p, 32'(o_rv[2 + p]), 32'd1);
        chk({nm, "_data_lat2"}, p, o_rd[2 + p], exp);
        chk({nm, "_single_lat1"}, p, 32'(o_rv[p]), 32'd0);
    endtask

    task automatic count_busy(input string nm, input int exp);
        int n0, n1, guard;
        n0 = 0; n1 = 0; guard = 0;
        while ((busy_w[0] || busy_w[1]) && guard < 5000) begin
            n0 += int'(busy_w[0]);
            n1 += int'(busy_w[1]);
            guard++;
            step();
        end
        chk(nm, 0, n0, exp);
        chk(nm, 1, n1, exp);
    endtask

    initial begin
        logic [31:0] q0 [$];
        logic [31:0] q1 [$];
        int idx;
        logic rr;
        for (int p = 0; p < 2; p++) begin
            t_addr[p] = '0; t_be[p] = '0; t_cs[p] = 0; t_rd[p] = 0; t_wr[p] = 0; t_ck[p] = 1; t_wd[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // power-up clear
        count_busy("reset_clear_cycles", DEPTH);
        rd_chk(0, 11'h7FF, 32'h0000_0000, "top_word_cleared");

        // byte-lane write then cross-port read, and an all-lanes-off write
        wr(0, 11'h010, 32'hDEAD_BEEF, 4'b0101);
        rd_chk(1, 11'h010, 32'h00AD_00EF, "byte_lanes");
        wr(0, 11'h050, 32'hFFFF_FFFF, 4'b0000);
        rd_chk(0, 11'h050, 32'h0000_0000, "be_zero_noop");

        // same-address dual write
        t_cs[0] = 1; t_wr[0] = 1; t_addr[0] = 11'h020; t_wd[0] = 32'h1111_1111; t_be[0] = 4'hF;
        t_cs[1] = 1; t_wr[1] = 1; t_addr[1] = 11'h020; t_wd[1] = 32'h2222_2222; t_be[1] = 4'hC;
        step();
        t_cs[0] = 0; t_wr[0] = 0; t_cs[1] = 0; t_wr[1] = 0;
        chk("collision_pulse", 0, 32'(coll_w[0]), 32'd1);
        step();
        chk("collision_one_cycle", 0, 32'(coll_w[0]), 32'd0);
        rd_chk(0, 11'h020, 32'h1111_1111, "dual_write");

        // different-address dual write: no collision, both land
        t_cs[0] = 1; t_wr[0] = 1; t_addr[0] = 11'h021; t_wd[0] = 32'h1234_5678; t_be[0] = 4'hF;
        t_cs[1] = 1; t_wr[1] = 1; t_addr[1] = 11'h022; t_wd[1] = 32'h9ABC_DEF0; t_be[1] = 4'h3;
        step();
        t_cs[0] = 0; t_wr[0] = 0; t_cs[1] = 0; t_wr[1] = 0;
        chk("no_collision", 0, 32'(coll_w[0]), 32'd0);
        rd_chk(1, 11'h022, 32'h0000_DEF0, "split_write");

        // read-during-write on the other port sees old data
        t_cs[0] = 1; t_wr[0] = 1; t_addr[0] = 11'h030; t_wd[0] = 32'hA5A5_A5A5; t_be[0] = 4'hF;
        t_cs[1] = 1; t_rd[1] = 1; t_addr[1] = 11'h030;
        step();
        t_cs[0] = 0; t_wr[0] = 0; t_cs[1] = 0; t_rd[1] = 0;
        chk("rdw_old_lat1", 1, o_rd[1], 32'h0000_0000);
        step();
        chk("rdw_old_lat2", 1, o_rd[3], 32'h0000_0000);
        rd_chk(1, 11'h030, 32'hA5A5_A5A5, "rdw_new");

        // clken low stalls only its own port
        t_ck[1] = 0; t_cs[1] = 1; t_rd[1] = 1; t_addr[1] = 11'h021;
        step();
        chk("clken_stall_wait", 1, 32'(o_wt[1]), 32'd1);
        step();
        t_ck[1] = 1;
        rd_chk(1, 11'h021, 32'h1234_5678, "clken_resume");

        // read stream with a 3-cycle freeze in the middle
        for (int i = 0; i < 8; i++) wr(0, 11'(11'h040 + i), 32'h0101_0101 * (i + 1), 4'hF);
        idx = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            reset_req = (cyc >= 3 && cyc <= 5);
            rr = reset_req;
            if (idx < 8) begin
                t_cs[0] = 1; t_rd[0] = 1; t_addr[0] = 11'(11'h040 + idx);
            end else begin
                t_cs[0] = 0; t_rd[0] = 0;
            end
            step();
            if (!rr && idx < 8) idx++;
            if (!rr && o_rv[0]) q0.push_back(o_rd[0]);
            if (!rr && o_rv[2]) q1.push_back(o_rd[2]);
        end
        reset_req = 0;
        chk("stream_beats", 0, q0.size(), 8);
        chk("stream_beats", 1, q1.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("stream_data_lat1", i, (i < q0.size()) ? q0[i] : 32'hXXXX_XXXX, 32'h0101_0101 * (i + 1));
            chk("stream_data_lat2", i, (i < q1.size()) ? q1[i] : 32'hXXXX_XXXX, 32'h0101_0101 * (i + 1));
        end

        // clear request with a read in flight
        clear_req = 1; t_cs[1] = 1; t_rd[1] = 1; t_addr[1] = 11'h030;
        step();
        clear_req = 0; t_cs[1] = 0; t_rd[1] = 0;
        chk("inflight_lat1", 1, o_rd[1], 32'hA5A5_A5A5);
        chk("inflight_busy", 0, 32'(busy_w[0]), 32'd1);
        step();
        chk("inflight_lat2", 1, o_rd[3], 32'hA5A5_A5A5);
        chk("inflight_valid_lat2", 1, 32'(o_rv[3]), 32'd1);
        count_busy("clear_req_cycles", DEPTH - 1);
        rd_chk(1, 11'h030, 32'h0000_0000, "after_clear");

        // reset part-way through a clear restarts it from zero
        clear_req = 1;
        step();
        clear_req = 0;
        repeat (100) step();
        reset = 1;
        step();
        reset = 0;
        count_busy("restart_clear_cycles", DEPTH);
        rd_chk(0, 11'h010, 32'h0000_0000, "after_restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
